// File: rtl/fifo_frame_reader_pkg.sv
// Shared types and constants for the ADC FIFO frame reader.
// Holds the FSM state encoding, the default sync word and the
// byte-select helpers that fix the MSB-first byte ordering on the wire.
package fifo_frame_reader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        LEN0,
        LEN1,
        RD_REQ,
        RD_WAIT,
        DAT0,
        DAT1,
        CSUM
    } frame_state_t;

    localparam logic [15:0] DEFAULT_HEADER = 16'hA55A;

    localparam int SAMPLE_CNT_W = 12;

    localparam int MSB_BYTE_LSB = 8;
    localparam int LSB_BYTE_LSB = 0;

    function automatic logic [7:0] msb_byte(input logic [15:0] word);
        return word[MSB_BYTE_LSB +: 8];
    endfunction

    function automatic logic [7:0] lsb_byte(input logic [15:0] word);
        return word[LSB_BYTE_LSB +: 8];
    endfunction

endpackage

// File: rtl/fifo_frame_reader.sv
// Read-side consumer of the ADC sample FIFO.
// Waits for a full frame to be buffered, then streams header, length,
// big-endian samples and an 8-bit modular checksum over a valid/ready
// byte interface. Every byte is a combinational function of the state and
// of registers that only change on acceptance, so a stalled byte is stable.
module fifo_frame_reader
    import fifo_frame_reader_pkg::*;
#(
    parameter int          FRAME_LEN = 1024,
    parameter int          USEDW_W   = 13,
    parameter logic [15:0] HEADER    = DEFAULT_HEADER
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [USEDW_W-1:0] RDUSEDW,
    input  logic               RDEMPTY,
    output logic               FIFO_RD,
    input  logic [15:0]        FIFO_OUT,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic [15:0]        frame_cnt
);

    localparam logic [15:0]             LEN_WORD        = 16'(FRAME_LEN);
    localparam logic [SAMPLE_CNT_W-1:0] FRAME_LEN_CNT   = SAMPLE_CNT_W'(FRAME_LEN);
    localparam logic [USEDW_W:0]        FRAME_LEN_USEDW = (USEDW_W + 1)'(FRAME_LEN);

    frame_state_t            state;
    frame_state_t            state_next;
    logic [15:0]             word_reg;
    logic [7:0]              sum;
    logic [SAMPLE_CNT_W-1:0] sample_cnt;
    logic [SAMPLE_CNT_W-1:0] sample_cnt_inc;
    logic                    accept;
    logic                    frame_avail;

    assign frame_avail    = !RDEMPTY && ({1'b0, RDUSEDW} >= FRAME_LEN_USEDW);
    assign sample_cnt_inc = sample_cnt + 1'b1;

    // State register: reset aborts any frame in progress on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: byte states advance only on a completed handshake
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_avail) begin
                    state_next = HDR0;
                end
            end
            HDR0: begin
                if (accept) begin
                    state_next = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    state_next = LEN0;
                end
            end
            LEN0: begin
                if (accept) begin
                    state_next = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!RDEMPTY) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_next = DAT0;
            end
            DAT0: begin
                if (accept) begin
                    state_next = DAT1;
                end
            end
            DAT1: begin
                if (accept) begin
                    if (sample_cnt_inc == FRAME_LEN_CNT) begin
                        state_next = CSUM;
                    end else begin
                        state_next = RD_REQ;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: byte mux, handshake, single-cycle FIFO read request
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        FIFO_RD  = 1'b0;
        busy     = (state != IDLE);
        case (state)
            HDR0: begin
                tx_valid = 1'b1;
                tx_data  = msb_byte(HEADER);
            end
            HDR1: begin
                tx_valid = 1'b1;
                tx_data  = lsb_byte(HEADER);
            end
            LEN0: begin
                tx_valid = 1'b1;
                tx_data  = msb_byte(LEN_WORD);
            end
            LEN1: begin
                tx_valid = 1'b1;
                tx_data  = lsb_byte(LEN_WORD);
            end
            RD_REQ: begin
                FIFO_RD = !RDEMPTY;
            end
            DAT0: begin
                tx_valid = 1'b1;
                tx_data  = msb_byte(word_reg);
            end
            DAT1: begin
                tx_valid = 1'b1;
                tx_data  = lsb_byte(word_reg);
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = sum;
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
        accept = tx_valid && tx_ready;
    end

    // Datapath: word capture, checksum, sample and frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg   <= 16'h0000;
            sum        <= 8'h00;
            sample_cnt <= '0;
            frame_cnt  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    sum        <= 8'h00;
                    sample_cnt <= '0;
                end
                LEN0, LEN1, DAT0: begin
                    if (accept) begin
                        sum <= sum + tx_data;
                    end
                end
                RD_WAIT: begin
                    word_reg <= FIFO_OUT;
                end
                DAT1: begin
                    if (accept) begin
                        sum        <= sum + tx_data;
                        sample_cnt <= sample_cnt_inc;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: begin
                    sum <= sum;
                end
            endcase
        end
    end

endmodule
